rr_mux_arb: RTL and testbench
=============================

# rr_mux_arb

Parametrised N-channel, W-bit multiplexer with round-robin arbitration, valid/ready handshakes on every channel and one registered output stage. It replaces the static sel-driven 4:1 mux wherever several producers share one consumer and selection must follow requests rather than an external select. It sits between N streaming sources and one downstream sink.

## Interface

Parameters:
- N, 4, number of input channels; legal range 2..16.
- W, 4, data width in bits; W >= 1.
- SW, $clog2(N), derived width of the channel index; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; release is synchronised externally.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel accept; at most one bit set per cycle; combinational.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered data of the held beat.
- out_sel  output  SW  registered index of the channel that sourced the held beat.
- out_ready  input  1  sink accepts the held beat.

## Operation

- Transfer on any port happens in a cycle where valid and ready are both 1 at the rising edge.
- load = !out_valid | out_ready. Arbitration runs only when load is 1.
- Grant: the first channel i with in_valid[i] = 1, scanning upward from (ptr + 1) mod N and wrapping. ptr holds the index of the last granted channel.
- in_ready[g] = load & grant_valid for the granted g; all other in_ready bits 0. in_ready never depends on in_valid of a different channel beyond the grant scan; it depends on out_ready combinationally.
- On a transfer from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g.
- load = 1 and no in_valid set: out_valid <= 0; out_data, out_sel, ptr hold.
- out_valid = 1 and out_ready = 0: out_data, out_sel, out_valid, ptr all hold; all in_ready = 0.
- Simultaneous consume and refill (out_ready = 1 while a request exists): no bubble; new beat replaces old in the same edge.
- in_data of non-granted channels is don't-care; X on those bits must not propagate to outputs.
- Fairness: with all N channels continuously requesting and out_ready = 1, grants cycle 0,1,...,N-1,0,... ; no channel waits more than N-1 transfers.

## Timing

- Reset values: out_valid = 0, out_data = 0, out_sel = 0, ptr = N-1 (so channel 0 has first priority after reset). in_ready follows combinationally: any in_valid after reset sees its ready immediately if it wins.
- Latency: input transfer at edge k -> out_valid = 1 with that data after edge k, visible in cycle k+1.
- Throughput: one beat per cycle while out_ready stays 1.
- Reset asserted mid-operation: outputs go to reset values asynchronously, held beat is dropped, ptr returns to N-1; in_ready forced to 0 while rst_n = 0.
- No combinational path from in_valid/in_data to out_valid/out_data/out_sel.

## Structure

- Shared package mux_pkg: function for packed-slice extraction helpers only if reused; no block-specific typedefs required. Channel index type is a local logic [SW-1:0].
- One sub-module: rr_arbiter (combinational; inputs req[N], ptr[SW]; outputs gnt_valid, gnt_idx[SW]). Reused by later multi-output variants.
- Top holds ptr, output register and in_ready decode.

## Test plan

N = 4, W = 4 unless stated.
- Reset: rst_n = 0 with in_valid = 4'b1111 -> out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0; after release first grant is channel 0.
- Single channel: in_valid = 4'b0100, in_data ch2 = 'hc, out_ready = 1 -> in_ready = 4'b0100, next cycle out_valid = 1, out_data = 'hc, out_sel = 2.
- Round-robin: in_valid = 4'b1111, data ch0..ch3 = 'ha,'hb,'hc,'hd, out_ready = 1 for 8 cycles -> out_data sequence a,b,c,d,a,b,c,d, one per cycle, no bubbles.
- Backpressure: beat 'hb held, out_ready = 0 for 3 cycles with all channels requesting -> out_data stays 'hb, out_sel stays 1, in_ready = 0 throughout; on out_ready = 1 next grant is channel 2.
- Wrap and skip: ptr = 3 (last grant ch3), in_valid = 4'b0101 -> grant ch0, then ch2, then ch0; X on in_data of ch1/ch3 never appears on out_data.
- Reset mid-stream: assert rst_n during round-robin with out_valid = 1 -> out_valid drops immediately; after release grant restarts at channel 0. Repeat round-robin case with N = 3, W = 8 to check parametrisation.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared helpers for the round-robin mux family.
package mux_pkg;

    // Channel index reached by stepping `off` places up from `base`, wrapping at n.
    function automatic int unsigned wrap_idx(int unsigned base, int unsigned off, int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester above ptr wins, scanning with wrap.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_valid,
    output logic [SW-1:0] gnt_idx
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Offset N lands back on ptr itself, so the last granted channel has lowest priority.
        for (int unsigned k = 1; k <= N; k++) begin
            if (!gnt_valid && req[wrap_idx(32'(ptr), k, N)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SW'(wrap_idx(32'(ptr), k, N));
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel round-robin mux with valid/ready handshakes and one registered output beat.
module rr_mux_arb
    import mux_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned W  = 4,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_sel,
    input  logic             out_ready
);

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic [SW-1:0] r_ptr;

    logic          w_load;
    logic          w_gnt_valid;
    logic [SW-1:0] w_gnt_idx;
    logic [W-1:0]  w_gnt_data;

    assign w_load = !r_out_valid || out_ready;

    rr_arbiter #(
        .N (N)
    ) u_arbiter (
        .req       (in_valid),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Only the granted slice is selected, so unknowns on other channels cannot leak.
    assign w_gnt_data = in_data[32'(w_gnt_idx) * W +: W];

    always_comb begin
        in_ready = '0;
        if (rst_n && w_load && w_gnt_valid) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= SW'(N - 1);
        end else if (w_load) begin
            if (w_gnt_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_sel   <= w_gnt_idx;
                r_ptr       <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: driver queues expected beats, negedge monitor consumes them.
module tb_rr_mux_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: N=4, W=4
    logic [3:0]  a_in_valid;
    logic [15:0] a_in_data;
    logic [3:0]  a_in_ready;
    logic        a_out_valid;
    logic [3:0]  a_out_data;
    logic [1:0]  a_out_sel;
    logic        a_out_ready;

    // DUT B: N=3, W=8
    logic [2:0]  b_in_valid;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_ready;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_sel;
    logic        b_out_ready;

    rr_mux_arb #(.N(4), .W(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel),
        .out_ready (a_out_ready)
    );

    rr_mux_arb #(.N(3), .W(8)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_ready (b_out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected beats: [15:8] = channel index, [7:0] = data.
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Called at posedge+1; drives one cycle, checks in_ready, queues the beat, returns at next posedge+1.
    task automatic cyc_a(input logic [3:0] vld, input logic rdy, input logic [15:0] dat,
                         input logic [3:0] exp_rdy);
        int g;
        a_in_valid  = vld;
        a_out_ready = rdy;
        a_in_data   = dat;
        #1;
        chk("a_in_ready", 32'(a_in_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0) begin
            g = oh2i(16'(exp_rdy));
            qa.push_back({8'(g), 4'h0, dat[g*4 +: 4]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic [2:0] vld, input logic rdy, input logic [23:0] dat,
                         input logic [2:0] exp_rdy);
        int g;
        b_in_valid  = vld;
        b_out_ready = rdy;
        b_in_data   = dat;
        #1;
        chk("b_in_ready", 32'(b_in_ready), 32'(exp_rdy));
        if (exp_rdy != 3'b0) begin
            g = oh2i(16'(exp_rdy));
            qb.push_back({8'(g), dat[g*8 +: 8]});
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_beat", 32'(a_out_data), 32'hffff_ffff);
            end else begin
                e = qa.pop_front();
                chk("a_out_data", 32'(a_out_data), 32'(e[3:0]));
                chk("a_out_sel", 32'(a_out_sel), 32'(e[9:8]));
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_beat", 32'(b_out_data), 32'hffff_ffff);
            end else begin
                e = qb.pop_front();
                chk("b_out_data", 32'(b_out_data), 32'(e[7:0]));
                chk("b_out_sel", 32'(b_out_sel), 32'(e[9:8]));
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 4'b1111;
        a_in_data   = 16'hdcba;
        a_out_ready = 1'b1;
        b_in_valid  = 3'b000;
        b_in_data   = 24'h0;
        b_out_ready = 1'b1;

        // Reset with all channels requesting
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'h0);
        chk("rst_out_valid", 32'(a_out_valid), 32'h0);
        chk("rst_out_data", 32'(a_out_data), 32'h0);
        chk("rst_out_sel", 32'(a_out_sel), 32'h0);
        rst_n = 1'b1;

        // Round-robin, 8 back-to-back beats a,b,c,d,a,b,c,d
        for (int i = 0; i < 8; i++) cyc_a(4'b1111, 1'b1, 16'hdcba, 4'b0001 << (i % 4));
        cyc_a(4'b0000, 1'b1, 16'hdcba, 4'b0000);
        chk("idle_out_valid", 32'(a_out_valid), 32'h0);

        // Single channel 2
        cyc_a(4'b0100, 1'b1, 16'h0c00, 4'b0100);
        chk("single_out_valid", 32'(a_out_valid), 32'h1);
        chk("single_out_data", 32'(a_out_data), 32'hc);
        chk("single_out_sel", 32'(a_out_sel), 32'h2);
        cyc_a(4'b0000, 1'b1, 16'h0000, 4'b0000);

        // Backpressure on held beat 'hb from channel 1
        cyc_a(4'b0010, 1'b1, 16'hdcba, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            cyc_a(4'b1111, 1'b0, 16'hdcba, 4'b0000);
            chk("bp_out_data", 32'(a_out_data), 32'hb);
            chk("bp_out_sel", 32'(a_out_sel), 32'h1);
        end
        cyc_a(4'b1111, 1'b1, 16'hdcba, 4'b0100);

        // Wrap and skip from ptr = 3, X on channels 1 and 3
        cyc_a(4'b1000, 1'b1, 16'hdcba, 4'b1000);
        cyc_a(4'b0101, 1'b1, 16'hx6x5, 4'b0001);
        cyc_a(4'b0101, 1'b1, 16'hx6x5, 4'b0100);
        cyc_a(4'b0101, 1'b1, 16'hx6x5, 4'b0001);

        // Reset mid-stream with a beat held
        cyc_a(4'b1111, 1'b1, 16'hdcba, 4'b0010);
        chk("mid_pre_out_valid", 32'(a_out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(a_out_valid), 32'h0);
        chk("mid_rst_in_ready", 32'(a_in_ready), 32'h0);
        qa.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc_a(4'b1111, 1'b1, 16'hdcba, 4'b0001);
        cyc_a(4'b1111, 1'b1, 16'hdcba, 4'b0010);
        cyc_a(4'b0000, 1'b1, 16'hdcba, 4'b0000);
        cyc_a(4'b0000, 1'b1, 16'hdcba, 4'b0000);
        chk("a_queue_drained", 32'(qa.size()), 32'h0);

        // Parametrisation: N=3, W=8 round-robin
        for (int i = 0; i < 6; i++) cyc_b(3'b111, 1'b1, 24'h332211, 3'b001 << (i % 3));
        cyc_b(3'b000, 1'b1, 24'h332211, 3'b000);
        cyc_b(3'b000, 1'b1, 24'h332211, 3'b000);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
